// File: rtl/alu_ser_pkg.sv
// alu_ser_pkg: shared types and widths for the ALU result serializer
//   state_t    : frame FSM states
//   RES_W      : ALU result width
//   ENTRY_W    : FIFO entry width ({flag, R})
//   FRAME_BITS : serial bits per frame
//   DATA_BITS  : result bits carried per frame
package alu_ser_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, FLAG, STOP} state_t;
   localparam int RES_W      = 5;
   localparam int ENTRY_W    = 6;
   localparam int FRAME_BITS = 8;
   localparam int DATA_BITS  = 5;
endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: small synchronous FIFO holding {flag, R} entries
//   clk, reset : clock, synchronous active-high reset
//   wr_en      : write request, accepted when not full or when popping
//   wr_data    : entry to write
//   rd_en      : pop request, ignored when empty
//   rd_data    : head entry, combinational
//   empty/full : occupancy status
module alu_result_fifo
   import alu_ser_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic               rd_en,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               empty,
   output logic               full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic wr_ok, rd_ok;
   assign empty   = count_q == '0;
   assign full    = count_q == CW'(DEPTH);
   assign rd_data = mem_q[rd_ptr_q];
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign wr_ok = wr_en && (!full || rd_en);
   assign rd_ok = rd_en && !empty;
   always_comb begin
      mem_d = mem_q;
      if (wr_ok) mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
   end
   always_ff @(posedge clk) mem_q <= mem_d;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: queues ALU results and sends each as an 8-bit serial frame
//   clk, reset      : clock, synchronous active-high reset
//   in_valid        : R_in/flag_in carry a new result
//   R_in, flag_in   : ALU result and flag
//   tx_out          : serial line, idles high (start, R[0..4], flag, stop)
//   busy            : frame in progress
//   full            : FIFO full
//   overflow        : sticky, a result was dropped
//   frames_sent     : completed frames modulo 256
module alu_result_serializer
   import alu_ser_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int BIT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [RES_W-1:0] R_in,
   input  logic             flag_in,
   output logic             tx_out,
   output logic             busy,
   output logic             full,
   output logic             overflow,
   output logic [7:0]       frames_sent
);
   localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [ENTRY_W-1:0] sh_q, sh_d, rd_data;
   logic [7:0] frames_q, frames_d;
   logic overflow_q, overflow_d;
   logic empty, pop, last;
   alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (in_valid),
      .wr_data ({flag_in, R_in}),
      .rd_en   (pop),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full)
   );
   assign last = cnt_q == CW'(BIT_CYCLES - 1);
   // A frame is loaded from IDLE, or straight out of the final stop-bit cycle.
   assign pop  = !empty && (state_q == IDLE || (state_q == STOP && last));
   assign tx_out = state_q == START ? 1'b0 :
                   state_q == DATA  ? sh_q[idx_q] :
                   state_q == FLAG  ? sh_q[ENTRY_W-1] : 1'b1;
   assign busy        = state_q != IDLE;
   assign overflow    = overflow_q;
   assign frames_sent = frames_q;
   always_comb begin
      state_d    = state_q;
      cnt_d      = last ? '0 : cnt_q + 1'b1;
      idx_d      = idx_q;
      sh_d       = pop ? rd_data : sh_q;
      frames_d   = frames_q;
      overflow_d = overflow_q | (in_valid & full & ~pop);
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!empty) state_d = START;
         end
         START: if (last) begin
            state_d = DATA;
            idx_d   = '0;
         end
         DATA: if (last) begin
            if (idx_q == 3'(DATA_BITS - 1)) state_d = FLAG;
            else idx_d = idx_q + 1'b1;
         end
         FLAG: if (last) state_d = STOP;
         STOP: if (last) begin
            frames_d = frames_q + 1'b1;
            state_d  = empty ? IDLE : START;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         sh_q       <= '0;
         frames_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sh_q       <= sh_d;
         frames_q   <= frames_d;
         overflow_q <= overflow_d;
      end
   end
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: directed self-checking bench for alu_result_serializer
module tb_alu_result_serializer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic [4:0] R_in = '0;
   logic flag_in = 1'b0;
   logic tx_out, busy, full, overflow;
   logic [7:0] frames_sent;
   int checks = 0;
   int failures = 0;
   alu_result_serializer #(.DEPTH(4), .BIT_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .R_in        (R_in),
      .flag_in     (flag_in),
      .tx_out      (tx_out),
      .busy        (busy),
      .full        (full),
      .overflow    (overflow),
      .frames_sent (frames_sent)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input logic [4:0] r, input logic f);
      in_valid = 1'b1;
      R_in     = r;
      flag_in  = f;
      tick();
      in_valid = 1'b0;
   endtask
   function automatic logic frame_bit(input logic [4:0] r, input logic f, input int i);
      if (i == 0) return 1'b0;
      if (i <= 5) return r[i-1];
      if (i == 6) return f;
      return 1'b1;
   endfunction
   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask
   logic [4:0] bb_r [3];
   logic       bb_f [3];
   initial begin
      bb_r[0] = 5'h01; bb_f[0] = 1'b0;
      bb_r[1] = 5'h1F; bb_f[1] = 1'b0;
      bb_r[2] = 5'h0A; bb_f[2] = 1'b1;
      repeat (3) tick();
      check("rst_tx", 32'(tx_out), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_frames", 32'(frames_sent), 32'd0);
      reset = 1'b0;
      tick();
      check("post_rst_tx", 32'(tx_out), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
      // single frame: R=10110 flag=1 -> 0,0,1,1,0,1,1,1
      wr(5'b10110, 1'b1);
      check("single_pre_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 32; i++) begin
         tick();
         check($sformatf("single_tx%0d", i), 32'(tx_out), 32'(frame_bit(5'b10110, 1'b1, i / 4)));
      end
      check("single_frames_pre", 32'(frames_sent), 32'd0);
      tick();
      check("single_frames", 32'(frames_sent), 32'd1);
      check("single_idle", 32'(busy), 32'd0);
      check("single_tx_idle", 32'(tx_out), 32'd1);
      // back-to-back: three writes, three contiguous frames
      wr(bb_r[0], bb_f[0]);
      wr(bb_r[1], bb_f[1]);
      check("b2b_start", 32'(tx_out), 32'd0);
      wr(bb_r[2], bb_f[2]);
      for (int i = 1; i < 96; i++) begin
         check($sformatf("b2b_tx%0d", i), 32'(tx_out), 32'(frame_bit(bb_r[i/32], bb_f[i/32], (i % 32) / 4)));
         check($sformatf("b2b_busy%0d", i), 32'(busy), 32'd1);
         tick();
      end
      check("b2b_frames", 32'(frames_sent), 32'd4);
      check("b2b_idle", 32'(busy), 32'd0);
      // overflow: six consecutive writes while idle
      for (int k = 0; k < 5; k++) wr(5'(k + 3), k[0]);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_not_yet", 32'(overflow), 32'd0);
      wr(5'h11, 1'b1);
      check("ovf_full2", 32'(full), 32'd1);
      check("ovf_set", 32'(overflow), 32'd1);
      wait_idle("ovf_drain", 400);
      check("ovf_frames", 32'(frames_sent), 32'd9);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_empty_full", 32'(full), 32'd0);
      // reset mid-frame during DATA bit 2 (R[2]=0 so tx is low there)
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check("mid_ovf_clr", 32'(overflow), 32'd0);
      check("mid_frames_clr", 32'(frames_sent), 32'd0);
      wr(5'b11011, 1'b1);
      repeat (13) tick();
      check("mid_tx_bit2", 32'(tx_out), 32'd0);
      check("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_tx", 32'(tx_out), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_full", 32'(full), 32'd0);
      repeat (3) tick();
      check("mid_fifo_empty", 32'(busy), 32'd0);
      check("mid_frames", 32'(frames_sent), 32'd0);
      // counter wrap: 256 frames paced one write per 32 clocks
      for (int k = 0; k < 256; k++) begin
         wr(5'(k), k[0]);
         repeat (31) tick();
      end
      check("wrap_255", 32'(frames_sent), 32'd255);
      check("wrap_busy", 32'(busy), 32'd1);
      wait_idle("wrap_drain", 100);
      check("wrap_frames", 32'(frames_sent), 32'd0);
      check("wrap_ovf", 32'(overflow), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Downstream stage of the 5-bit ALU FSM. Each valid ALU result (5-bit `R` plus `flag`) is captured into a small FIFO. Each entry is then shifted out on one serial line as an 8-bit frame, so results can be observed off-chip or by a bench monitor. It also reports FIFO status, a sticky overflow, and a count of frames sent.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `BIT_CYCLES`, 4: clocks per serial bit (≥1).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `R_in`/`flag_in` hold a new result this cycle.
- `R_in`  in  5  ALU result.
- `flag_in`  in  1  ALU flag.
- `tx_out`  out  1  serial frame output, idles high.
- `busy`  out  1  a frame is in progress (FSM not IDLE).
- `full`  out  1  FIFO holds `DEPTH` entries.
- `overflow`  out  1  sticky: a result was dropped.
- `frames_sent`  out  8  completed frames, modulo 256.

## Operation
- **Frame format, 8 bits, in order:**
  - start bit (0);
  - `R[0]` through `R[4]`, LSB first;
  - `flag`;
  - stop bit (1).
- **FIFO write:** when `in_valid=1`, write `{flag_in,R_in}` if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise drop the result and set `overflow=1`.
  - `overflow` stays set until reset.
- **FIFO pop:** happens only on the cycle the FSM loads a frame.
- **FSM states:** IDLE, START, DATA, FLAG, STOP.
  - IDLE: `tx_out=1`. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx_out=0` for `BIT_CYCLES`, then go to DATA.
  - DATA: drive 5 bits LSB first, `BIT_CYCLES` each, using a bit index from 0 to 4. Then go to FLAG.
  - FLAG: drive the stored flag for `BIT_CYCLES`, then go to STOP.
  - STOP: `tx_out=1` for `BIT_CYCLES`. On the last cycle, increment `frames_sent` (255 wraps to 0).
    - If the FIFO is non-empty, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- **Counters:**
  - Bit-cycle counter: 0 to `BIT_CYCLES-1`, cleared on every state change.
  - FIFO occupancy counter: range 0 to `DEPTH`. Read/write pointers wrap modulo `DEPTH`.
- **Reset** (including mid-frame) clears:
  - the FIFO;
  - the FSM, to IDLE;
  - all counters;
  - `overflow`.

  The partial frame is abandoned and `tx_out` returns high.

## Timing
- **Values during reset and on the cycle after it:** `tx_out=1`, `busy=0`, `full=0`, `overflow=0`, `frames_sent=0`.
- **Write latency:** data presented with `in_valid` at edge N is in the FIFO after edge N.
- **Frame start latency:** with the FSM in IDLE and the FIFO empty, a write at edge N causes:
  - the pop and the transition to START at edge N+1;
  - `tx_out` low and `busy` high after edge N+1.
- **Frame length:** 8×`BIT_CYCLES` clocks. Each bit is stable for exactly `BIT_CYCLES` cycles.
- **Back-to-back frames:** the next start bit begins the cycle after the last stop-bit cycle.
- **`full` and `overflow`:**
  - `full` is registered and reflects occupancy after the edge.
  - `overflow` asserts the cycle after the dropped write.
- **Simultaneous write and pop while empty** (in IDLE): cannot occur, because the pop requires non-empty. The write simply lands.
- **Outputs:** `busy`, `tx_out` and `frames_sent` are registered outputs (no combinational path from the inputs).

## Structure
- **Package `alu_ser_pkg`:**
  - state enum (IDLE, START, DATA, FLAG, STOP);
  - `RES_W=5`, `ENTRY_W=6`, `FRAME_BITS=8`, `DATA_BITS=5`.
- **Sub-module `alu_result_fifo`** (parameter `DEPTH`; synchronous reset):
  - inputs: `wr_en`, `wr_data[5:0]`, `rd_en`;
  - outputs: `rd_data`, `empty`, `full`.
  - Read data is available combinationally at the head.
- **Top level:** FSM, shift register, bit/cycle counters, `overflow` and `frames_sent` registers.

## Test plan
All scenarios use `BIT_CYCLES=4` and `DEPTH=4`.
- **Reset values:** hold `reset` for 3 cycles → `tx_out=1`, `busy=0`, `full=0`, `overflow=0`, `frames_sent=0`.
- **Single frame:** write `R=5'b10110`, `flag=1` → `tx_out` shows 0,0,1,1,0,1,1,1 (4 clocks each) starting 1 cycle after the write. `frames_sent=1` after 32 clocks.
- **Back-to-back:** write 3 results on consecutive cycles → 3 contiguous frames (96 clocks, no high gap between frames). `frames_sent=3`, then `busy=0`.
- **Overflow:** write 6 results on consecutive cycles while idle.
  - The first is popped immediately, 4 fill the FIFO, and the 6th is dropped.
  - Expect `full=1`, `overflow=1`, and exactly 5 frames sent.
- **Reset mid-frame:** assert `reset` during DATA bit 2 → `tx_out=1` and `busy=0` the next cycle. The FIFO is empty and the frame count is unchanged from 0.
- **Counter wrap:** send 256 frames → `frames_sent` returns to 0. `overflow` remains 0 when writes are paced one per 32 clocks.
